// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: MSB-first, back-to-back framing over a valid/ready load handshake.
// Optional even-parity trailer bit is enabled by defining PISO_PARITY_EN.
module piso_serializer #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [SIZE-1:0] PI,
    input  logic            load_valid,
    output logic            load_ready,
    output logic            SO,
    output logic            SO_valid,
    output logic            done
);

    // state | meaning
    // IDLE  | no transfer in progress, line held at 0
    // SHIFT | a frame is on the line
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int CW = $clog2(SIZE + 1);
`ifdef PISO_PARITY_EN
    localparam logic [CW-1:0] LAST = CW'(SIZE);
`else
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);
`endif

    state_t          state_q, state_d;
    logic [SIZE-1:0] sreg_q, sreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            so_q, so_d;
    logic            so_valid_q, so_valid_d;
    logic            done_q, done_d;
    logic            accept;
`ifdef PISO_PARITY_EN
    logic            parity_q, parity_d;
`endif

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        so_d       = 1'b0;
        so_valid_d = 1'b0;
        done_d     = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d   = parity_q;
`endif
        load_ready = (state_q == IDLE) || ((state_q == SHIFT) && done_q);
        accept     = load_valid && load_ready;

        if (accept) begin
            // A new word may start on the very edge that ends the previous frame.
            state_d    = SHIFT;
            sreg_d     = PI;
            cnt_d      = '0;
            so_d       = PI[SIZE-1];
            so_valid_d = 1'b1;
            done_d     = (LAST == '0);
`ifdef PISO_PARITY_EN
            parity_d   = ^PI;
`endif
        end else if (state_q == SHIFT) begin
            if (done_q) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                sreg_d     = sreg_q << 1;
                cnt_d      = cnt_q + 1'b1;
                so_d       = sreg_d[SIZE-1];
                so_valid_d = 1'b1;
                done_d     = (cnt_d == LAST);
`ifdef PISO_PARITY_EN
                if (cnt_q == CW'(SIZE - 1)) begin
                    so_d = parity_q;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            cnt_q      <= '0;
            so_q       <= 1'b0;
            so_valid_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            cnt_q      <= cnt_d;
            so_q       <= so_d;
            so_valid_q <= so_valid_d;
            done_q     <= done_d;
`ifdef PISO_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign SO       = so_q;
    assign SO_valid = so_valid_q;
    assign done     = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: per-cycle compare against a bit-queue model plus literal frame checks.
module tb_piso_serializer;

    localparam int SIZE = 4;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = SIZE + PAR;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [SIZE-1:0] PI = '0;
    logic            load_valid = 1'b0;
    logic            load_ready;
    logic            SO;
    logic            SO_valid;
    logic            done;

    always #5 clk = ~clk;

    piso_serializer #(.SIZE(SIZE)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .PI         (PI),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .SO         (SO),
        .SO_valid   (SO_valid),
        .done       (done)
    );

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a frame is just the list of bits it must emit; one bit leaves per edge.
    bit qb[$];
    bit cur_so = 1'b0;
    bit cur_v = 1'b0;
    bit cur_done = 1'b0;

    function automatic bit m_ready();
        return !cur_v || cur_done;
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            qb.delete();
            cur_so = 1'b0; cur_v = 1'b0; cur_done = 1'b0;
        end else begin
            if (load_valid && m_ready()) begin
                qb.delete();
                for (int i = SIZE - 1; i >= 0; i--) qb.push_back(PI[i]);
                if (PAR == 1) qb.push_back(^PI);
            end
            if (qb.size() > 0) begin
                cur_so   = qb.pop_front();
                cur_v    = 1'b1;
                cur_done = (qb.size() == 0);
            end else begin
                cur_so = 1'b0; cur_v = 1'b0; cur_done = 1'b0;
            end
        end
    end

    logic [31:0] log_so = '0;
    logic [31:0] log_done = '0;
    int          log_n = 0;

    always @(negedge clk) begin
        if (checking) begin
            chk("SO", 32'(SO), 32'(cur_so));
            chk("SO_valid", 32'(SO_valid), 32'(cur_v));
            chk("done", 32'(done), 32'(cur_done));
            chk("load_ready", 32'(load_ready), 32'(m_ready()));
            if (SO_valid === 1'b1) begin
                log_so   = {log_so[30:0], SO};
                log_done = {log_done[30:0], done};
                log_n++;
            end
        end
    end

    task automatic clear_log();
        log_so = '0; log_done = '0; log_n = 0;
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send(input logic [SIZE-1:0] w, input bit hold_after);
        int n;
        PI = w;
        load_valid = 1'b1;
        n = 0;
        while (load_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (load_ready !== 1'b1) begin
            tests++; fails++;
            $display("FAIL send_timeout got load_ready=%0b expected=1", load_ready);
        end
        @(negedge clk);
        if (!hold_after) load_valid = 1'b0;
    endtask

    task automatic check_log(input string name, input int n, input logic [31:0] bits, input logic [31:0] dn);
        chk({name, "_len"}, 32'(log_n), 32'(n));
        chk({name, "_bits"}, log_so, bits);
        chk({name, "_done"}, log_done, dn);
    endtask

    initial begin
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checking = 1'b1;
        chk("rst_SO", 32'(SO), 32'd0);
        chk("rst_SO_valid", 32'(SO_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        rstn = 1'b1;
        @(negedge clk);

        // Single word 1011; PI is scrambled right after accept and must not matter.
        clear_log();
        send(4'b1011, 1'b0);
        PI = 4'b0000;
        repeat (FL + 2) @(negedge clk);
`ifdef PISO_PARITY_EN
        check_log("w1011", 5, 32'b10111, 32'b00001);
`else
        check_log("w1011", 4, 32'b1011, 32'b0001);
`endif

        clear_log();
        send(4'b1001, 1'b0);
        repeat (FL + 2) @(negedge clk);
`ifdef PISO_PARITY_EN
        check_log("w1001", 5, 32'b10010, 32'b00001);
`else
        check_log("w1001", 4, 32'b1001, 32'b0001);
`endif

        // Back-to-back: 5 presented as load_ready rises on done.
        clear_log();
        send(4'hA, 1'b0);
        send(4'h5, 1'b0);
        repeat (FL + 2) @(negedge clk);
`ifdef PISO_PARITY_EN
        check_log("b2b", 10, 32'b1010001010, 32'b0000100001);
`else
        check_log("b2b", 8, 32'b10100101, 32'b00010001);
`endif

        // Stall: 3 held valid during the A frame.
        clear_log();
        send(4'hA, 1'b1);
        send(4'h3, 1'b0);
        repeat (FL + 2) @(negedge clk);
`ifdef PISO_PARITY_EN
        check_log("stall", 10, 32'b1010000110, 32'b0000100001);
`else
        check_log("stall", 8, 32'b10100011, 32'b00010001);
`endif

        // Mid-frame reset during the 2nd bit of F.
        clear_log();
        send(4'hF, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("mrst_SO", 32'(SO), 32'd0);
        chk("mrst_SO_valid", 32'(SO_valid), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_load_ready", 32'(load_ready), 32'd1);
        rstn = 1'b1;
        repeat (FL + 1) @(negedge clk);
        check_log("mrst", 2, 32'b11, 32'b00);

        // Reset and accept on the same edge: reset wins.
        clear_log();
        rstn = 1'b0;
        PI = 4'hC;
        load_valid = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        load_valid = 1'b0;
        chk("rst_accept_SO_valid", 32'(SO_valid), 32'd0);
        repeat (FL + 1) @(negedge clk);
        chk("rst_accept_len", 32'(log_n), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog got=timeout expected=finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
